// File: rtl/axi_mem_slave.sv
// Single-port AXI slave memory model: one read or write burst at a time,
// incrementing word bursts, programmable read latency for miss-penalty studies.
module axi_mem_slave #(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 14,
   parameter int READ_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [3:0]            BID,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  protocol_err
);
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP} state_t;

   state_t                state;
   logic [3:0]            id_q, len_q, beat_q;
   logic [DEPTH_LOG2-1:0] addr_q, rd_idx;
   logic [LW-1:0]         lat_q;
   logic                  prio_rd, rvalid_q, wready_q, bvalid_q, perr_q;
   logic                  ar_go, aw_go, last_beat, r_fire, w_fire;
   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [DATA_WIDTH-1:0] ram_q;
   logic                  unused_addr_bits;

   // prio_rd=1 favours read when both address channels are valid
   assign ar_go     = (state == IDLE) && ARVALID && (!AWVALID || prio_rd);
   assign aw_go     = (state == IDLE) && AWVALID && (!ARVALID || !prio_rd);
   assign last_beat = (beat_q == len_q);
   assign r_fire    = rvalid_q && RREADY;
   assign w_fire    = wready_q && WVALID;

   // Look one word ahead on a read handshake so the RAM output register
   // already holds the next beat and bursts stream one beat per cycle.
   assign rd_idx = r_fire ? addr_q + 1'b1 : addr_q;

   always_ff @(posedge clk) begin
      if (w_fire) mem[addr_q] <= WDATA;
      ram_q <= mem[rd_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         id_q     <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         addr_q   <= '0;
         lat_q    <= '0;
         prio_rd  <= 1'b1;
         rvalid_q <= 1'b0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_go) begin
                  id_q    <= ARID;
                  len_q   <= ARLEN;
                  addr_q  <= ARADDR[DEPTH_LOG2+1:2];
                  beat_q  <= '0;
                  lat_q   <= LAT_INIT;
                  prio_rd <= 1'b0;
                  state   <= RD_WAIT;
               end else if (aw_go) begin
                  id_q     <= AWID;
                  len_q    <= AWLEN;
                  addr_q   <= AWADDR[DEPTH_LOG2+1:2];
                  beat_q   <= '0;
                  prio_rd  <= 1'b1;
                  wready_q <= 1'b1;
                  state    <= WR_DATA;
               end
            end
            RD_WAIT: begin
               if (lat_q == '0) begin
                  rvalid_q <= 1'b1;
                  state    <= RD_BURST;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            RD_BURST: begin
               if (RREADY) begin
                  addr_q <= addr_q + 1'b1;
                  beat_q <= beat_q + 4'd1;
                  if (last_beat) begin
                     rvalid_q <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            WR_DATA: begin
               if (WVALID) begin
                  addr_q <= addr_q + 1'b1;
                  beat_q <= beat_q + 4'd1;
                  if ((WLAST != last_beat) || (WID != id_q)) perr_q <= 1'b1;
                  // AWLEN alone decides the end of the data phase
                  if (last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     state    <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (BREADY) begin
                  bvalid_q <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ARREADY      = ar_go;
   assign AWREADY      = aw_go;
   assign WREADY       = wready_q;
   assign BVALID       = bvalid_q;
   assign BID          = bvalid_q ? id_q : 4'd0;
   assign RVALID       = rvalid_q;
   assign RLAST        = rvalid_q && last_beat;
   assign RID          = rvalid_q ? id_q : 4'd0;
   assign RDATA        = rvalid_q ? ram_q : '0;
   assign protocol_err = perr_q;

   assign unused_addr_bits = ^{ARADDR[ADDR_WIDTH-1:DEPTH_LOG2+2], ARADDR[1:0],
                               AWADDR[ADDR_WIDTH-1:DEPTH_LOG2+2], AWADDR[1:0]};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_axi_mem_slave;
   localparam int AW = 26, DW = 32, DL = 4, LAT = 4;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          AWVALID = 0, AWREADY, WVALID = 0, WREADY, WLAST = 0;
   logic [3:0]    AWID = 0, AWLEN = 0, WID = 0, BID, ARID = 0, ARLEN = 0, RID;
   logic [AW-1:0] AWADDR = 0, ARADDR = 0;
   logic [DW-1:0] WDATA = 0, RDATA;
   logic          BVALID, BREADY = 1, ARVALID = 0, ARREADY, RVALID, RREADY = 1, RLAST;
   logic          protocol_err;

   axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] data; logic [3:0] id; logic last;} rbeat_t;

   rbeat_t     rd_q[$];
   logic [3:0] b_q[$];
   int         n_cmp = 0, n_err = 0;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endfunction

   function automatic void fail(string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no handshake/event, required one within bound", nm);
   endfunction

   // ---------------- monitor ----------------
   rbeat_t     r_hold, r_exp;
   logic       r_stall = 0, b_stall = 0;
   logic [3:0] b_hold;

   always @(negedge clk) begin
      if (!rst_n) begin
         r_stall = 0;
         b_stall = 0;
      end else begin
         if (r_stall && RVALID) begin
            check("r_stall_data", RDATA, r_hold.data);
            check("r_stall_id", RID, r_hold.id);
            check("r_stall_last", RLAST, r_hold.last);
         end
         if (RVALID && RREADY) begin
            if (rd_q.size() == 0) fail("r_unexpected_beat");
            else begin
               r_exp = rd_q.pop_front();
               check("rdata", RDATA, r_exp.data);
               check("rid", RID, r_exp.id);
               check("rlast", RLAST, r_exp.last);
            end
         end
         r_stall = RVALID && !RREADY;
         r_hold  = '{RDATA, RID, RLAST};
         if (b_stall && BVALID) check("b_stall_id", BID, b_hold);
         if (BVALID && BREADY) begin
            if (b_q.size() == 0) fail("b_unexpected_resp");
            else check("bid", BID, b_q.pop_front());
         end
         b_stall = BVALID && !BREADY;
         b_hold  = BID;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_req(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id,
                         output int lat);
      int t = 0;
      ARADDR = a; ARLEN = len; ARID = id; ARVALID = 1;
      @(negedge clk);
      while (!ARREADY && t < 100) begin @(negedge clk); t++; end
      if (!ARREADY) fail("ar_handshake");
      tick();
      ARVALID = 0;
      lat = 0;
      while (!RVALID && lat < 100) begin tick(); lat++; end
   endtask

   task automatic aw_req(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id);
      int t = 0;
      AWADDR = a; AWLEN = len; AWID = id; AWVALID = 1;
      @(negedge clk);
      while (!AWREADY && t < 100) begin @(negedge clk); t++; end
      if (!AWREADY) fail("aw_handshake");
      tick();
      AWVALID = 0;
   endtask

   task automatic w_data(input logic [3:0] len, input logic [3:0] id, input logic [31:0] base,
                         input int last_at);
      for (int i = 0; i <= int'(len); i++) begin
         int t = 0;
         WVALID = 1; WDATA = base + 32'(i); WID = id; WLAST = (i == last_at);
         @(negedge clk);
         while (!WREADY && t < 100) begin @(negedge clk); t++; end
         if (!WREADY) fail("w_handshake");
         tick();
      end
      WVALID = 0;
      WLAST  = 0;
   endtask

   task automatic wait_rd_done(string nm);
      int t = 0;
      while (rd_q.size() != 0 && t < 200) begin tick(); t++; end
      if (rd_q.size() != 0) begin fail(nm); rd_q.delete(); end
   endtask

   task automatic wait_b_done(string nm);
      int t = 0;
      while (b_q.size() != 0 && t < 200) begin tick(); t++; end
      if (b_q.size() != 0) begin fail(nm); b_q.delete(); end
   endtask

   task automatic write_burst(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id,
                              input logic [31:0] base, input int last_at);
      b_q.push_back(id);
      aw_req(a, len, id);
      w_data(len, id, base, last_at);
      wait_b_done("b_done");
   endtask

   task automatic arb_round(input logic exp_rd, input string nm);
      int   t = 0;
      logic got_rd;
      ARADDR = 26'h14; ARLEN = 0; ARID = 4'h6;
      AWADDR = 26'h20; AWLEN = 0; AWID = 4'h7;
      ARVALID = 1; AWVALID = 1;
      @(negedge clk);
      while (!ARREADY && !AWREADY && t < 100) begin @(negedge clk); t++; end
      check({nm, "_arready"}, ARREADY, exp_rd);
      check({nm, "_awready"}, AWREADY, !exp_rd);
      got_rd = ARREADY;
      if (ARREADY) rd_q.push_back('{32'hDEADBEEF, 4'h6, 1'b1});
      else if (AWREADY) b_q.push_back(4'h7);
      else fail({nm, "_grant"});
      tick();
      ARVALID = 0; AWVALID = 0;
      if (got_rd) wait_rd_done({nm, "_rd_done"});
      else begin
         w_data(0, 4'h7, 32'h77, 0);
         wait_b_done({nm, "_b_done"});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int lat;
      // reset values
      #12;
      check("rst_arready", ARREADY, 0);
      check("rst_awready", AWREADY, 0);
      check("rst_wready", WREADY, 0);
      check("rst_bvalid", BVALID, 0);
      check("rst_rvalid", RVALID, 0);
      check("rst_rdata", RDATA, 0);
      check("rst_perr", protocol_err, 0);
      tick();
      rst_n = 1;
      tick();

      // single write then single read, latency 4
      write_burst(26'h14, 0, 4'h2, 32'hDEADBEEF, 0);
      rd_q.push_back('{32'hDEADBEEF, 4'h3, 1'b1});
      ar_req(26'h14, 0, 4'h3, lat);
      check("single_latency", lat, 4);
      wait_rd_done("single_rd_done");

      // burst write 1..4, burst read back
      write_burst(26'h40, 3, 4'h5, 32'd1, 3);
      for (int i = 1; i <= 4; i++) rd_q.push_back('{32'(i), 4'h4, i == 4});
      ar_req(26'h40, 3, 4'h4, lat);
      check("burst_latency", lat, 4);
      wait_rd_done("burst_rd_done");
      check("perr_clean", protocol_err, 0);

      // read backpressure: RREADY 1,0,0,1
      for (int i = 1; i <= 4; i++) rd_q.push_back('{32'(i), 4'hA, i == 4});
      RREADY = 1;
      ar_req(26'h40, 3, 4'hA, lat);
      tick(); RREADY = 0;
      tick();
      tick(); RREADY = 1;
      wait_rd_done("bp_rd_done");

      // write response backpressure
      BREADY = 0;
      b_q.push_back(4'h9);
      aw_req(26'h60, 0, 4'h9);
      w_data(0, 4'h9, 32'h55, 0);
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", BVALID, 1);
         check("bp_bid", BID, 4'h9);
         tick();
      end
      BREADY = 1;
      wait_b_done("bp_b_done");

      // arbitration, last served was a write
      arb_round(1'b1, "arb1");
      arb_round(1'b0, "arb2");
      arb_round(1'b1, "arb3");

      // wrap at word 15 -> 0 with early WLAST
      write_burst(26'h38, 3, 4'h1, 32'hA0, 1);
      check("perr_set", protocol_err, 1);
      for (int i = 0; i < 4; i++) rd_q.push_back('{32'hA0 + 32'(i), 4'hB, i == 3});
      ar_req(26'h38, 3, 4'hB, lat);
      wait_rd_done("wrap_rd_done");
      check("perr_sticky", protocol_err, 1);

      // async reset in the middle of a stalled read burst
      RREADY = 0;
      ar_req(26'h40, 3, 4'hE, lat);
      check("pre_rst_rvalid", RVALID, 1);
      #2 rst_n = 0;
      #1;
      check("mid_rst_rvalid", RVALID, 0);
      check("mid_rst_rlast", RLAST, 0);
      check("mid_rst_rid", RID, 0);
      check("mid_rst_rdata", RDATA, 0);
      check("mid_rst_perr", protocol_err, 0);
      check("mid_rst_bvalid", BVALID, 0);
      tick();
      tick();
      rst_n  = 1;
      RREADY = 1;
      tick();
      rd_q.push_back('{32'hDEADBEEF, 4'hC, 1'b1});
      ar_req(26'h14, 0, 4'hC, lat);
      check("post_rst_latency", lat, 4);
      wait_rd_done("post_rst_rd_done");

      check("rd_q_drained", rd_q.size(), 0);
      check("b_q_drained", b_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Single-port AXI slave memory model. Sits directly downstream of the core's external AXI port and serves the core's instruction-cache and data-cache refills and writebacks.
- Accepts one transaction at a time, read or write, with incrementing word bursts of AWLEN/ARLEN+1 beats.
- Read latency is programmable, so cache miss penalties can be exercised in simulation and on FPGA.

Parameters:
- ADDR_WIDTH, 26: byte address width, matching the core.
- DATA_WIDTH, 32: beat and word width.
- DEPTH_LOG2, 14: log2 of the number of words in the backing array.
- READ_LATENCY, 4: cycles from the AR handshake to the first RVALID, minimum 1.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWID  in  4  write transaction ID
AWLEN  in  4  write burst length minus 1
AWADDR  in  ADDR_WIDTH  write start byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WLAST  in  1  last write beat
WID  in  4  write data ID
WDATA  in  DATA_WIDTH  write data
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BID  out  4  write response ID
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARID  in  4  read transaction ID
ARLEN  in  4  read burst length minus 1
ARADDR  in  ADDR_WIDTH  read start byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RLAST  out  1  last read beat
RID  out  4  read data ID
RDATA  out  DATA_WIDTH  read data
protocol_err  out  1  sticky flag for WLAST or WID mismatch

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs are 0, including protocol_err.
  - The round-robin priority bit is reset to favour read.
  - Memory array contents are not reset.
  - If rst_n is asserted mid-burst, the transaction is abandoned with no response.
- States: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP.
- IDLE:
  - ARREADY and AWREADY are combinationally high only in IDLE, gated by arbitration.
  - If only ARVALID is high, accept it and go to RD_WAIT.
  - If only AWVALID is high, accept it and go to WR_DATA.
  - If both are high, grant the side not served last; the other side's READY stays low.
  - On accept, latch ID, LEN, and word address = ADDR[DEPTH_LOG2+1:2]. ADDR[1:0] is ignored.
- RD_WAIT:
  - Counter loads READY_LATENCY-1 on AR accept and decrements each cycle.
  - At 0, go to RD_BURST with RVALID=1.
  - The first RVALID therefore occurs exactly READ_LATENCY cycles after the AR handshake cycle.
- RD_BURST:
  - RDATA = mem[word address], RID = latched ID, RLAST = 1 when the beat counter equals LEN.
  - RDATA, RID and RLAST are held stable while RVALID && !RREADY.
  - On RVALID && RREADY, increment the word address (wraps modulo 2^DEPTH_LOG2) and the beat counter.
  - RVALID stays high back-to-back, one beat per cycle if RREADY is held.
  - After the handshake with RLAST=1, drop RVALID and return to IDLE.
- WR_DATA:
  - WREADY=1. On WVALID && WREADY, write mem[word address] = WDATA and increment address and beat counter.
  - The beat with counter == LEN ends the data phase regardless of WLAST; go to WR_RESP.
  - Set protocol_err if WLAST differs from (counter == LEN) on any beat, or if WID differs from AWID.
  - Extra beats after an early WLAST are not accepted outside WR_DATA.
- WR_RESP: BVALID=1, BID = latched ID; hold until BREADY, then go to IDLE.
- A write followed by a read to the same address returns the new data (no bypass needed, since transactions are serialized).
- The priority bit flips to "last served" on each AR or AW accept.
- Memory is inferred as a synchronous-read RAM. The RDATA prefetch for the next beat must preserve the one-beat-per-cycle throughput.

Test Plan:
- Single read: write mem[5]=0xDEADBEEF via AW addr 0x14, LEN 0; then AR addr 0x14, ARID 3, RREADY=1 → RVALID exactly 4 cycles after the AR handshake, RDATA=0xDEADBEEF, RID=3, RLAST=1, one beat only.
- Burst write then read: AW addr 0x40, LEN 3, WDATA 1..4 with WLAST on beat 4 → BVALID with matching BID. AR addr 0x40, LEN 3 → 4 consecutive beats 1,2,3,4, RLAST only on the 4th, protocol_err=0.
- Backpressure: during the read burst, RREADY toggles 1,0,0,1 → RDATA, RLAST and RID are stable while stalled, no beat is skipped or duplicated. BREADY held low 5 cycles → BVALID and BID are held.
- Simultaneous AR and AW in IDLE, repeated 3 times → grants alternate read, write, read. The losing READY stays 0 until its turn.
- Wrap and error: DEPTH_LOG2=4, AW word address 14, LEN 3 → writes words 14, 15, 0, 1. A WLAST asserted on beat 2 → protocol_err=1 and sticky until reset.
- Async reset mid RD_BURST → all outputs 0 immediately. After reset release, a new AR is accepted in IDLE with normal latency.
